// File: rtl/alu_wb_if.sv
// Writeback handshake bundle: upstream ALU result channel plus downstream
// register-file channel.
interface alu_wb_if #(
    parameter int DW = 16,
    parameter int RW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_r;
    logic          in_z;
    logic          in_n;
    logic          in_c;
    logic [RW-1:0] in_rd;
    logic          in_we;
    logic          in_fe;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic [RW-1:0] out_rd;
    logic          out_we;

    modport master (
        output in_valid, in_r, in_z, in_n, in_c, in_rd, in_we, in_fe, out_ready,
        input  in_ready, out_valid, out_r, out_rd, out_we
    );

    modport slave (
        input  in_valid, in_r, in_z, in_n, in_c, in_rd, in_we, in_fe, out_ready,
        output in_ready, out_valid, out_r, out_rd, out_we
    );
endinterface

// File: rtl/alu_wb.sv
// ALU writeback stage: 2-entry result FIFO toward the register file, the
// architectural flag register with condition evaluation, and a retire counter.
module alu_wb #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_wb_if.slave    bus,
    input  logic [2:0] cond,
    output logic       cond_true,
    output logic [2:0] flags,
    output logic [7:0] retire_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] r_q  [2];
    logic [RW-1:0] rd_q [2];
    logic          we_q [2];
    logic [2:0]    flags_q;
    logic [7:0]    retire_q;
    logic          push, pop;

    // Handshake readiness depends only on registered state, never on out_ready.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_r  = r_q[rd_ptr_q];
    assign bus.out_rd = rd_q[rd_ptr_q];
    assign bus.out_we = we_q[rd_ptr_q];

    assign flags      = flags_q;
    assign retire_cnt = retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push && !pop) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:  if (!push && pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            r_q[0]   <= '0;
            r_q[1]   <= '0;
            rd_q[0]  <= '0;
            rd_q[1]  <= '0;
            we_q[0]  <= 1'b0;
            we_q[1]  <= 1'b0;
            flags_q  <= 3'b000;
            retire_q <= 8'd0;
        end else begin
            if (push) begin
                r_q[wr_ptr_q]  <= bus.in_r;
                rd_q[wr_ptr_q] <= bus.in_rd;
                we_q[wr_ptr_q] <= bus.in_we;
                wr_ptr_q       <= ~wr_ptr_q;
                // Flags only follow accepted results; a stalled in_fe is dropped.
                if (bus.in_fe) begin
                    flags_q <= {bus.in_z, bus.in_n, bus.in_c};
                end
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                retire_q <= retire_q + 8'd1;
            end
        end
    end

    // flags_q is {z, n, c}
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = flags_q[2];
            3'b010: cond_true = !flags_q[2];
            3'b011: cond_true = flags_q[1];
            3'b100: cond_true = !flags_q[1];
            3'b101: cond_true = flags_q[0];
            3'b110: cond_true = !flags_q[0];
            3'b111: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end
endmodule
